sprite_cmd_queue: RTL and testbench

SPRITE_CMD_QUEUE -- requirements
Module: sprite_cmd_queue

---
 rtl/sprite_cmd_pkg.sv | 41 ++++
 rtl/sync_fifo.sv | 52 +++++
 rtl/sprite_cmd_queue.sv | 129 ++++++++++++
 tb/tb_sprite_cmd_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_cmd_pkg.sv
// rtl/sprite_cmd_pkg.sv - sprite command word layout, info codes and queue FSM states
package sprite_cmd_pkg;

   localparam int DEPTH_DEFAULT = 32;

   // Sprite command word field positions
   localparam int SUB_COMP_MSB   = 31;
   localparam int SUB_COMP_LSB   = 26;
   localparam int CHILD_COMP_MSB = 25;
   localparam int CHILD_COMP_LSB = 21;
   localparam int INFO_MSB       = 20;
   localparam int INFO_LSB       = 17;
   localparam int INPUT_TYPE_MSB = 16;
   localparam int INPUT_TYPE_LSB = 14;
   localparam int BUF_SEL_BIT    = 13;
   localparam int INPUT_MSG_MSB  = 12;
   localparam int INPUT_MSG_LSB  = 0;

   localparam logic [3:0] INFO_WRITE = 4'b0001;
   localparam logic [3:0] INFO_SWAP  = 4'b1111;

   // Queue entries carry the command word plus a commit-marker flag on top
   localparam int ENTRY_W    = 33;
   localparam int MARKER_BIT = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_VB
   } state_t;

   // Swap broadcast: only info and the newly selected buffer are non-zero
   function automatic logic [31:0] swap_word(input logic new_front);
      logic [31:0] w;
      w = '0;
      w[INFO_MSB:INFO_LSB] = INFO_SWAP;
      w[BUF_SEL_BIT]       = new_front;
      return w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy level
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_full  = (r_count == FULL_LVL);
   assign o_empty = (r_count == '0);
   assign o_level = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   // Pointer and occupancy bookkeeping; reset drops all queued entries
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   // Storage array; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/sprite_cmd_queue.sv
// rtl/sprite_cmd_queue.sv - CPU sprite command queue with vblank-synchronised buffer swap
module sprite_cmd_queue
   import sprite_cmd_pkg::*;
#(
   parameter int DEPTH       = DEPTH_DEFAULT,
   parameter int VBLANK_LINE = 480
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     chipselect,
   input  logic                     write,
   input  logic                     address,
   input  logic [31:0]              writedata,
   output logic                     waitrequest,
   input  logic [9:0]               hcount,
   input  logic [9:0]               vcount,
   output logic [31:0]              cmd_out,
   output logic                     front_buffer,
   output logic                     frame_done,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [9:0] VB_LINE = 10'(VBLANK_LINE);

   state_t             r_state;
   state_t             w_next;
   logic [31:0]        r_cmd;
   logic [31:0]        w_cmd_next;
   logic               r_front;
   logic               r_frame_done;
   logic               w_swap;
   logic               w_pop;
   logic               w_accept;
   logic               w_push;
   logic [ENTRY_W-1:0] w_push_data;
   logic [31:0]        w_cmd_word;
   logic [ENTRY_W-1:0] w_head;
   logic               w_full;
   logic               w_empty;
   logic [LW-1:0]      w_level;
   logic               w_strobe;

   assign waitrequest  = w_full;
   assign cmd_out      = r_cmd;
   assign front_buffer = r_front;
   assign frame_done   = r_frame_done;
   assign fifo_level   = w_level;
   assign w_strobe     = (hcount == 10'd0) && (vcount == VB_LINE);
   assign w_accept     = chipselect & write & ~w_full;

   // Commands are retargeted to the back buffer; CPU swap requests are dropped
   always_comb begin
      w_cmd_word              = writedata;
      w_cmd_word[BUF_SEL_BIT] = ~r_front;
      w_push                  = 1'b0;
      w_push_data             = {1'b0, w_cmd_word};
      if (w_accept) begin
         if (address) begin
            w_push      = 1'b1;
            w_push_data = {1'b1, 32'h0};
         end else begin
            w_push = (writedata[INFO_MSB:INFO_LSB] != INFO_SWAP);
         end
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .resetn      (reset),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_level     (w_level)
   );

   // Issue decision: drain commands, park on a marker until the vblank strobe
   always_comb begin
      w_next     = r_state;
      w_pop      = 1'b0;
      w_cmd_next = 32'h0;
      w_swap     = 1'b0;
      case (r_state)
         ST_IDLE, ST_ISSUE: begin
            if (w_empty) begin
               w_next = ST_IDLE;
            end else if (w_head[MARKER_BIT]) begin
               if (w_strobe) w_swap = 1'b1;
               else          w_next = ST_WAIT_VB;
            end else begin
               w_pop      = 1'b1;
               w_cmd_next = w_head[31:0];
               w_next     = ST_ISSUE;
            end
         end
         ST_WAIT_VB: begin
            if (w_strobe) w_swap = 1'b1;
         end
         default: w_next = ST_IDLE;
      endcase
      if (w_swap) begin
         w_pop      = 1'b1;
         w_cmd_next = swap_word(~r_front);
         w_next     = ((w_level > LW'(1)) || w_push) ? ST_ISSUE : ST_IDLE;
      end
   end

   // State, broadcast word and front-buffer registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_cmd        <= 32'h0;
         r_front      <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_cmd        <= w_cmd_next;
         r_frame_done <= w_swap;
         if (w_swap) r_front <= ~r_front;
      end
   end

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// tb/tb_sprite_cmd_queue.sv - self-checking bench for sprite_cmd_queue
module tb_sprite_cmd_queue;

   localparam int DEPTH = 32;

   logic        clk;
   logic        reset;
   logic        chipselect;
   logic        write;
   logic        address;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic [31:0] cmd_out;
   logic        front_buffer;
   logic        frame_done;
   logic [5:0]  fifo_level;

   int n_checks = 0;
   int n_errors = 0;
   int n_fd     = 0;
   int n_cmd    = 0;

   logic [32:0] mq[$];
   logic        m_front = 1'b0;
   logic        m_valid = 1'b0;

   sprite_cmd_queue #(.DEPTH(DEPTH), .VBLANK_LINE(480)) dut (
      .clk          (clk),
      .reset        (reset),
      .chipselect   (chipselect),
      .write        (write),
      .address      (address),
      .writedata    (writedata),
      .waitrequest  (waitrequest),
      .hcount       (hcount),
      .vcount       (vcount),
      .cmd_out      (cmd_out),
      .front_buffer (front_buffer),
      .frame_done   (frame_done),
      .fifo_level   (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        rstn;
      logic        cs;
      logic        wr;
      logic        addr;
      logic [31:0] wd;
      logic        strobe;
      logic [31:0] e_cmd;
      logic        e_front;
      logic        e_fd;
      int          e_lvl;
   } vec_t;

   vec_t tv[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rstn, input logic cs, input logic wr, input logic addr,
                        input logic [31:0] wd, input logic strobe);
      int sel;
      reset      = rstn;
      chipselect = cs;
      write      = wr;
      address    = addr;
      writedata  = wd;
      if (strobe) begin
         hcount = 10'd0;
         vcount = 10'd480;
      end else begin
         sel = $urandom_range(0, 3);
         if (sel == 0) begin
            hcount = 10'd0;
            vcount = 10'($urandom_range(0, 479));
         end else if (sel == 1) begin
            hcount = 10'($urandom_range(1, 799));
            vcount = 10'd480;
         end else begin
            hcount = 10'($urandom_range(0, 799));
            vcount = 10'($urandom_range(0, 479));
            if (hcount == 10'd0) hcount = 10'd7;
         end
      end
   endtask

   // One clock against the queue-based reference model
   task automatic cycle(input logic rstn, input logic cs, input logic wr, input logic addr,
                        input logic [31:0] wd, input logic strobe);
      logic [32:0] ent;
      logic        do_push;
      logic        full;
      logic        st;
      logic [31:0] e_cmd;
      logic        e_fd;
      drive(rstn, cs, wr, addr, wd, strobe);
      #1;
      st   = (hcount == 10'd0) && (vcount == 10'd480);
      full = (mq.size() == DEPTH);
      if (m_valid) chk("waitrequest", {31'b0, waitrequest}, {31'b0, full});
      e_cmd = 32'h0;
      e_fd  = 1'b0;
      if (!rstn) begin
         mq.delete();
         m_front = 1'b0;
         m_valid = 1'b1;
      end else begin
         do_push = 1'b0;
         ent     = '0;
         if (cs && wr && !full) begin
            if (addr) begin
               ent     = {1'b1, 32'h0};
               do_push = 1'b1;
            end else if (wd[20:17] != 4'hF) begin
               ent     = {1'b0, wd};
               ent[13] = ~m_front;
               do_push = 1'b1;
            end
         end
         if (mq.size() > 0) begin
            if (!mq[0][32]) begin
               e_cmd = mq[0][31:0];
               void'(mq.pop_front());
            end else if (st) begin
               e_cmd     = 32'h001E0000;
               e_cmd[13] = ~m_front;
               m_front   = ~m_front;
               e_fd      = 1'b1;
               void'(mq.pop_front());
            end
         end
         if (do_push) mq.push_back(ent);
      end
      @(posedge clk);
      #1;
      chk("cmd_out", cmd_out, e_cmd);
      chk("front_buffer", {31'b0, front_buffer}, {31'b0, m_front});
      chk("frame_done", {31'b0, frame_done}, {31'b0, e_fd});
      chk("fifo_level", {26'b0, fifo_level}, 32'(mq.size()));
      if (frame_done) n_fd++;
      if (cmd_out != 32'h0 && cmd_out[20:17] != 4'hF) n_cmd++;
   endtask

   function automatic logic [31:0] rand_cmd();
      logic [31:0] w;
      w        = $urandom;
      w[20:17] = 4'b0001;
      return w;
   endfunction

   initial begin
      //            rstn cs   wr   addr wd            strb e_cmd         fr   fd   lvl
      tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0};
      tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h04022005, 1'b0, 32'h0,        1'b0, 1'b0, 1};
      tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h04022005, 1'b0, 1'b0, 0};
      tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0};
      tv[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h001E0000, 1'b0, 32'h0,        1'b0, 1'b0, 0};
      tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0};
      tv[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h04020123, 1'b0, 32'h0,        1'b0, 1'b0, 1};
      tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h04022123, 1'b0, 1'b0, 1};
      tv[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h08040000, 1'b0, 32'h0,        1'b0, 1'b0, 2};
      tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h001E2000, 1'b1, 1'b1, 1};
      tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h08042000, 1'b1, 1'b0, 0};
      tv[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h08042000, 1'b0, 32'h0,        1'b1, 1'b0, 1};
      tv[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h08040000, 1'b1, 1'b0, 0};
      tv[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1};
      tv[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h001E0000, 1'b0, 1'b1, 0};
      tv[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0};

      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) begin
         drive(tv[i].rstn, tv[i].cs, tv[i].wr, tv[i].addr, tv[i].wd, tv[i].strobe);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d cmd_out", i), cmd_out, tv[i].e_cmd);
         chk($sformatf("vec%0d front_buffer", i), {31'b0, front_buffer}, {31'b0, tv[i].e_front});
         chk($sformatf("vec%0d frame_done", i), {31'b0, frame_done}, {31'b0, tv[i].e_fd});
         chk($sformatf("vec%0d fifo_level", i), {26'b0, fifo_level}, 32'(tv[i].e_lvl));
         if (i == 0) chk("vec0 waitrequest", {31'b0, waitrequest}, 32'h0);
      end

      // Three commands, commit, two commands; swap on the vblank strobe
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      n_fd  = 0;
      n_cmd = 0;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, rand_cmd(), 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, rand_cmd(), 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("commit frame_done pulses", 32'(n_fd), 32'd1);
      chk("commit front after swap", {31'b0, front_buffer}, 32'd1);
      chk("commit commands issued", 32'(n_cmd), 32'd5);

      // Fill behind a marker, hold the 33rd write, then drain
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      n_cmd = 0;
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
      for (int i = 0; i < 31; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, rand_cmd(), 1'b0);
      chk("full level", {26'b0, fifo_level}, 32'd32);
      chk("full waitrequest", {31'b0, waitrequest}, 32'd1);
      begin
         logic [31:0] held;
         held = rand_cmd();
         cycle(1'b1, 1'b1, 1'b1, 1'b0, held, 1'b0);
         chk("held level", {26'b0, fifo_level}, 32'd32);
         cycle(1'b1, 1'b1, 1'b1, 1'b0, held, 1'b1);
         cycle(1'b1, 1'b1, 1'b1, 1'b0, held, 1'b0);
      end
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("full drain count", 32'(n_cmd), 32'd32);
      chk("full drain level", {26'b0, fifo_level}, 32'd0);

      // Reset while parked on a marker with entries queued
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, rand_cmd(), 1'b0);
      chk("wait_vb level", {26'b0, fifo_level}, 32'd5);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("reset level", {26'b0, fifo_level}, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("reset no swap frame_done", {31'b0, frame_done}, 32'd0);
      chk("reset no swap front", {31'b0, front_buffer}, 32'd0);
      chk("reset no swap cmd_out", cmd_out, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic        rr, cs, wr, ad, st;
         logic [31:0] wd;
         rr = ($urandom_range(0, 499) != 0);
         cs = ($urandom_range(0, 3) != 0);
         wr = ($urandom_range(0, 3) != 0);
         ad = ($urandom_range(0, 7) == 0);
         wd = $urandom;
         if ($urandom_range(0, 9) == 0) wd[20:17] = 4'hF;
         st = ($urandom_range(0, 39) == 0);
         cycle(rr, cs, wr, ad, wd, st);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
